entry_sequencer: RTL and testbench

ENTRY_SEQUENCER -- requirements
Module: entry_sequencer

---
 rtl/entry_sequencer_pkg.sv | 20 ++
 rtl/entry_sequencer_button_conditioner.sv | 56 +++++
 rtl/entry_sequencer.sv | 121 ++++++++++++
 tb/tb_entry_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/entry_sequencer_pkg.sv
// Shared types and constants for the digit entry sequencer.
package entry_sequencer_pkg;

  typedef enum logic [1:0] {
    ENTER_A,
    ENTER_B,
    REQ,
    DONE
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [11:0] operand_t;

  // New digit enters at the least significant position; the oldest falls off.
  function automatic operand_t shift_in(input operand_t op, input logic [3:0] digit);
    return {op[7:0], digit};
  endfunction

endpackage

// File: rtl/entry_sequencer_button_conditioner.sv
// Button synchronizer, optional debounce (DEBOUNCE_EN) and rising-edge press detector.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic press_o
);

  logic sync1_q, sync2_q;
  logic level;
  logic level_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Saturating run-length of consecutive high synchronized samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!sync2_q) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = (cnt_q == CW'(DEBOUNCE_CYCLES));
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level;
    end
  end

  assign press_o = level & ~level_prev_q;

endmodule

// File: rtl/entry_sequencer.sv
// Collects two 3-digit BCD operands from switches + button and hands them to an ALU.
// Optional button debounce is enabled with the DEBOUNCE_EN macro.
module entry_sequencer
  import entry_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ag,
  input  logic       bg,
  input  logic       cg,
  input  logic       dg,
  input  logic       button,
  input  logic       clear,
  input  logic       ack,
  output operand_t   first_num,
  output operand_t   second_num,
  output logic       operand_sel,
  output logic [1:0] digit_idx,
  output logic       start,
  output logic       err
);

  state_e     state_q, state_d;
  operand_t   a_q, a_d;
  operand_t   b_q, b_d;
  logic       sel_q, sel_d;
  logic [1:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic       press;
  logic [3:0] digit;

  assign digit = {ag, bg, cg, dg};

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_conditioner (
    .clk_i   (clk),
    .rst_ni  (rst),
    .button_i(button),
    .press_o (press)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    err_d   = 1'b0;

    if (clear) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = 1'b0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ENTER_A, ENTER_B: begin
          if (press) begin
            if (digit > BCD_MAX) begin
              err_d = 1'b1;
            end else begin
              if (state_q == ENTER_A) a_d = shift_in(a_q, digit);
              else                    b_d = shift_in(b_q, digit);
              if (idx_q == 2'd2) begin
                idx_d   = '0;
                sel_d   = 1'b1;
                state_d = (state_q == ENTER_A) ? ENTER_B : REQ;
              end else begin
                idx_d = idx_q + 2'd1;
              end
            end
          end
        end
        REQ: begin
          if (ack) state_d = DONE;
        end
        DONE: begin
          // The restarting press only rearms entry; its digit is not taken.
          if (press) begin
            state_d = ENTER_A;
            a_d     = '0;
            b_d     = '0;
            sel_d   = 1'b0;
            idx_d   = '0;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  assign first_num   = a_q;
  assign second_num  = b_q;
  assign operand_sel = sel_q;
  assign digit_idx   = idx_q;
  assign start       = (state_q == REQ);
  assign err         = err_q;

endmodule

// File: tb/tb_entry_sequencer.sv
// Self-checking bench for entry_sequencer: behavioural model plus directed literal checks.
module tb_entry_sequencer;

`ifdef DEBOUNCE_EN
  localparam int unsigned DB = 4;
`else
  localparam int unsigned DB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ag, bg, cg, dg;
  logic        button, clear, ack;
  logic [11:0] first_num, second_num;
  logic        operand_sel;
  logic [1:0]  digit_idx;
  logic        start, err;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  bit cmp_en = 1'b0;

  entry_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ag         (ag),
    .bg         (bg),
    .cg         (cg),
    .dg         (dg),
    .button     (button),
    .clear      (clear),
    .ack        (ack),
    .first_num  (first_num),
    .second_num (second_num),
    .operand_sel(operand_sel),
    .digit_idx  (digit_idx),
    .start      (start),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = entering A, 1 = entering B, 2 = waiting for ack, 3 = finished
  int          m_mode;
  logic [11:0] m_a, m_b;
  logic        m_sel;
  logic [1:0]  m_idx;
  logic        m_err;
  logic [15:0] bh;  // bh[0] = button sampled at the previous edge, bh[1] one earlier, ...

  int          n_mode;
  logic [11:0] n_a, n_b;
  logic        n_sel;
  logic [1:0]  n_idx;
  logic        n_err;
  logic        m_press;
  logic [3:0]  m_digit;

  function automatic bit all_high(input logic [15:0] h, input int s, input int len);
    for (int i = 0; i < len; i++) if (!h[s+i]) return 1'b0;
    return 1'b1;
  endfunction

  // A press is consumed at this edge if the conditioned level rose one cycle ago.
  function automatic bit press_now(input logic [15:0] h);
    if (DB == 0) return h[1] && !h[2];
    return all_high(h, 2, DB) && !all_high(h, 3, DB);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0; m_a <= '0; m_b <= '0; m_sel <= 1'b0; m_idx <= '0; m_err <= 1'b0; bh <= '0;
    end else begin
      m_press = press_now(bh);
      m_digit = {ag, bg, cg, dg};
      n_mode = m_mode; n_a = m_a; n_b = m_b; n_sel = m_sel; n_idx = m_idx; n_err = 1'b0;
      if (clear) begin
        n_mode = 0; n_a = '0; n_b = '0; n_sel = 1'b0; n_idx = '0;
      end else if ((m_mode == 0 || m_mode == 1) && m_press) begin
        if (m_digit > 9) n_err = 1'b1;
        else begin
          if (m_mode == 0) n_a = 12'((m_a * 16 + m_digit) % 4096);
          else             n_b = 12'((m_b * 16 + m_digit) % 4096);
          if (m_idx == 2) begin n_idx = 0; n_sel = 1'b1; n_mode = m_mode + 1; end
          else n_idx = m_idx + 2'd1;
        end
      end else if (m_mode == 2 && ack) begin
        n_mode = 3;
      end else if (m_mode == 3 && m_press) begin
        n_mode = 0; n_a = '0; n_b = '0; n_sel = 1'b0; n_idx = '0;
      end
      bh <= {bh[14:0], button};
      m_mode <= n_mode; m_a <= n_a; m_b <= n_b; m_sel <= n_sel; m_idx <= n_idx; m_err <= n_err;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && cmp_en) begin
      chk("first_num", 32'(first_num), 32'(m_a));
      chk("second_num", 32'(second_num), 32'(m_b));
      chk("operand_sel", 32'(operand_sel), 32'(m_sel));
      chk("digit_idx", 32'(digit_idx), 32'(m_idx));
      chk("start", 32'(start), 32'(m_mode == 2));
      chk("err", 32'(err), 32'(m_err));
    end
    if (rst === 1'b1 && err === 1'b1) err_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_digit(input logic [3:0] d);
    {ag, bg, cg, dg} = d;
  endtask

  task automatic press(input logic [3:0] d);
    set_digit(d);
    button = 1'b1;
    step(1 + DB);
    button = 1'b0;
    step(4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_first"}, 32'(first_num), 0);
    chk({tag, "_second"}, 32'(second_num), 0);
    chk({tag, "_sel"}, 32'(operand_sel), 0);
    chk({tag, "_idx"}, 32'(digit_idx), 0);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  int e0;

  initial begin
    rst = 1'b0; button = 1'b0; clear = 1'b0; ack = 1'b0;
    set_digit(4'd0);
    step(3);
    chk_all_zero("reset");
    rst = 1'b1;
    cmp_en = 1'b1;
    step(2);

    // invalid digit with one digit already entered
    press(4'd1);
    e0 = err_seen;
    press(4'd12);
    chk("err_pulse_count", 32'(err_seen - e0), 1);
    chk("err_first_held", 32'(first_num), 32'h001);
    chk("err_idx_held", 32'(digit_idx), 1);

    press(4'd2); press(4'd3);
    chk("a_done_sel", 32'(operand_sel), 1);
    chk("a_done_idx", 32'(digit_idx), 0);
    press(4'd4); press(4'd5); press(4'd6);
    chk("entry_first", 32'(first_num), 32'h123);
    chk("entry_second", 32'(second_num), 32'h456);
    chk("entry_start", 32'(start), 1);
    chk("entry_sel", 32'(operand_sel), 1);

    // presses in REQ are ignored; start holds until ack
    press(4'd9);
    chk("req_press_first", 32'(first_num), 32'h123);
    chk("req_press_second", 32'(second_num), 32'h456);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("req_hold_start", 32'(start), 1);
    end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("done_start", 32'(start), 0);
    chk("done_first", 32'(first_num), 32'h123);
    step(2);
    chk("done_second", 32'(second_num), 32'h456);

    press(4'd5);
    chk_all_zero("restart");

    // held button yields one press only
    set_digit(4'd7);
    button = 1'b1;
    step(20);
    button = 1'b0;
    step(4);
    chk("hold_first", 32'(first_num), 32'h007);
    chk("hold_idx", 32'(digit_idx), 1);

    press(4'd0); press(4'd0);
    press(4'd4); press(4'd5);
    chk("b_partial", 32'(second_num), 32'h045);
    #3 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    #2 rst = 1'b1;
    step(2);

    // clear coincides with the edge consuming a press
    press(4'd8);
    chk("pre_clear_first", 32'(first_num), 32'h008);
    set_digit(4'd3);
    button = 1'b1;
    step(1 + DB);
    button = 1'b0;
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear_press_first", 32'(first_num), 0);
    chk("clear_press_idx", 32'(digit_idx), 0);
    step(5);
    chk("clear_press_after", 32'(first_num), 0);

`ifdef DEBOUNCE_EN
    set_digit(4'd2);
    button = 1'b1;
    step(3);
    button = 1'b0;
    step(10);
    chk("glitch_first", 32'(first_num), 0);
    button = 1'b1;
    step(6);
    button = 1'b0;
    step(10);
    chk("debounced_first", 32'(first_num), 32'h002);
`endif

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) button = ~button;
      set_digit(4'($urandom_range(0, 15)));
      ack   = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        #2 rst = 1'b1;
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
